pe_array_ctrl: RTL

Frame-level sequencer for an array of background-removal processing elements (`pe`). It starts the sum phase on all PEs and waits for every PE to finish. It then reduces the per-PE colour sums into an average background colour, drives that colour as `red_exp`/`green_exp`/`blue_exp`, and runs the background-removal phase. It sits between the frame-buffer loader and the PE array, and owns the PEs' `Start_Sum`, `Start_BgRemoval` and `Ack` inputs.

---
 rtl/pe_array_ctrl.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/pe_array_ctrl.sv
// pe_array_ctrl
// Frame-level sequencer for an array of background-removal PEs.
// It starts the sum phase, waits for every PE, reduces the per-PE colour
// sums into an average background colour, then runs background removal.
//
// Ports:
//   Clk, Reset                 clock, synchronous active-high reset
//   Start                      frame request, sampled only in IDLE
//   Sum_Done, Bg_Done          per-PE completion flags (all bits must be set)
//   red/green/blue_sum_in      flattened per-PE sums, PE k at [k*SUM_W +: SUM_W]
//   Start_Sum, Start_BgRemoval, Ack   broadcast controls to all PEs
//   red/green/blue_exp         averaged, saturated background colour
//   Busy, Done, Err            status (Done is a one-cycle pulse, Err is sticky)
//   Qi..Qd                     one-hot state bits
//
// Handshake: Start is a level request that is only looked at in IDLE and is
// never queued. Sum_Done/Bg_Done are levels held by the PEs; the wait
// states advance only when every bit is high. Ack releases the PEs.
module pe_array_ctrl #(
    parameter int NUM_PE     = 4,
    parameter int SUM_W      = 16,
    parameter int LOG2_TOTAL = 2,
    parameter int TIMEOUT    = 1023
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Start,
    input  logic [NUM_PE-1:0]       Sum_Done,
    input  logic [NUM_PE-1:0]       Bg_Done,
    input  logic [NUM_PE*SUM_W-1:0] red_sum_in,
    input  logic [NUM_PE*SUM_W-1:0] green_sum_in,
    input  logic [NUM_PE*SUM_W-1:0] blue_sum_in,
    output logic                    Start_Sum,
    output logic                    Start_BgRemoval,
    output logic                    Ack,
    output logic [7:0]              red_exp,
    output logic [7:0]              green_exp,
    output logic [7:0]              blue_exp,
    output logic                    Busy,
    output logic                    Done,
    output logic                    Err,
    output logic                    Qi,
    output logic                    Qss,
    output logic                    Qsw,
    output logic                    Qacc,
    output logic                    Qavg,
    output logic                    Qbs,
    output logic                    Qbw,
    output logic                    Qd
);

    localparam int IW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int AW = SUM_W + $clog2(NUM_PE);
    localparam int TW = $clog2(TIMEOUT + 1);

    // One-hot encoding: each state bit is its own flop, so the Moore
    // outputs below are straight flop outputs.
    typedef enum logic [7:0] {
        S_IDLE      = 8'h01,
        S_SUM_START = 8'h02,
        S_SUM_WAIT  = 8'h04,
        S_ACCUM     = 8'h08,
        S_AVG       = 8'h10,
        S_BG_START  = 8'h20,
        S_BG_WAIT   = 8'h40,
        S_DONE      = 8'h80
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   acc_r_q, acc_r_d;
    logic [AW-1:0]   acc_g_q, acc_g_d;
    logic [AW-1:0]   acc_b_q, acc_b_d;
    logic [7:0]      exp_r_q, exp_r_d;
    logic [7:0]      exp_g_q, exp_g_d;
    logic [7:0]      exp_b_q, exp_b_d;
    logic            err_q, err_d;

    logic [SUM_W-1:0] red_sel, green_sel, blue_sel;
    logic [TW-1:0]    cnt_inc;

    assign red_sel   = red_sum_in[idx_q*SUM_W +: SUM_W];
    assign green_sel = green_sum_in[idx_q*SUM_W +: SUM_W];
    assign blue_sel  = blue_sum_in[idx_q*SUM_W +: SUM_W];
    assign cnt_inc   = cnt_q + TW'(1);

    // Average = total >> LOG2_TOTAL, clamped to the 8-bit colour range.
    function automatic logic [7:0] avg_sat(input logic [AW-1:0] acc);
        logic [AW-1:0] sh;
        sh = acc >> LOG2_TOTAL;
        if (sh > AW'(255)) begin
            return 8'hFF;
        end
        return sh[7:0];
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        acc_r_d = acc_r_q;
        acc_g_d = acc_g_q;
        acc_b_d = acc_b_q;
        exp_r_d = exp_r_q;
        exp_g_d = exp_g_q;
        exp_b_d = exp_b_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_SUM_START;
                    err_d   = 1'b0;
                end
            end
            S_SUM_START: begin
                cnt_d   = '0;
                state_d = S_SUM_WAIT;
            end
            S_SUM_WAIT: begin
                // Done flags win over a timeout landing on the same edge.
                if (&Sum_Done) begin
                    state_d = S_ACCUM;
                    idx_d   = '0;
                    acc_r_d = '0;
                    acc_g_d = '0;
                    acc_b_d = '0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TW'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_ACCUM: begin
                acc_r_d = acc_r_q + AW'(red_sel);
                acc_g_d = acc_g_q + AW'(green_sel);
                acc_b_d = acc_b_q + AW'(blue_sel);
                idx_d   = idx_q + IW'(1);
                if (idx_q == IW'(NUM_PE - 1)) begin
                    state_d = S_AVG;
                end
            end
            S_AVG: begin
                exp_r_d = avg_sat(acc_r_q);
                exp_g_d = avg_sat(acc_g_q);
                exp_b_d = avg_sat(acc_b_q);
                state_d = S_BG_START;
            end
            S_BG_START: begin
                cnt_d   = '0;
                state_d = S_BG_WAIT;
            end
            S_BG_WAIT: begin
                if (&Bg_Done) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TW'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            acc_r_q <= '0;
            acc_g_q <= '0;
            acc_b_q <= '0;
            exp_r_q <= '0;
            exp_g_q <= '0;
            exp_b_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            acc_r_q <= acc_r_d;
            acc_g_q <= acc_g_d;
            acc_b_q <= acc_b_d;
            exp_r_q <= exp_r_d;
            exp_g_q <= exp_g_d;
            exp_b_q <= exp_b_d;
            err_q   <= err_d;
        end
    end

    assign Qi   = state_q[0];
    assign Qss  = state_q[1];
    assign Qsw  = state_q[2];
    assign Qacc = state_q[3];
    assign Qavg = state_q[4];
    assign Qbs  = state_q[5];
    assign Qbw  = state_q[6];
    assign Qd   = state_q[7];

    assign Start_Sum       = state_q[1];
    assign Start_BgRemoval = state_q[5];
    assign Ack             = state_q[4] | state_q[7];
    assign Done            = state_q[7];
    assign Busy            = ~state_q[0];
    assign Err             = err_q;

    assign red_exp   = exp_r_q;
    assign green_exp = exp_g_q;
    assign blue_exp  = exp_b_q;

endmodule
